// File: rtl/ddr3_fetch_rbuf.sv
// ddr3_fetch_rbuf: read-side reservation buffer in front of the DDR3 bypass AXI4 read port.
// A burst is issued only when the FIFO can hold every beat, so m_rready never stalls a burst.
module ddr3_fetch_rbuf #(
    parameter int WIDTH = 32,
    parameter int ADDRS = 23,
    parameter int REQID = 4,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             s_arvalid,
    output logic             s_arready,
    input  logic [ADDRS-1:0] s_araddr,
    input  logic [REQID-1:0] s_arid,
    input  logic [7:0]       s_arlen,
    input  logic [1:0]       s_arburst,
    output logic             s_rvalid,
    input  logic             s_rready,
    output logic             s_rlast,
    output logic [1:0]       s_rresp,
    output logic [REQID-1:0] s_rid,
    output logic [WIDTH-1:0] s_rdata,
    output logic             m_arvalid,
    input  logic             m_arready,
    output logic [ADDRS-1:0] m_araddr,
    output logic [REQID-1:0] m_arid,
    output logic [7:0]       m_arlen,
    output logic [1:0]       m_arburst,
    output logic             m_rready,
    input  logic             m_rvalid,
    input  logic             m_rlast,
    input  logic [1:0]       m_rresp,
    input  logic [WIDTH-1:0] m_rdata,
    output logic             err_o
);

    localparam int ABITS = $clog2(DEPTH);
    localparam int EW    = 1 + 2 + REQID + WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic [8:0]     DEPTH9 = 9'(DEPTH);
    localparam logic [ABITS:0] FULLC  = (ABITS + 1)'(DEPTH);

    logic [1:0]       state_q, state_d;
    logic [ADDRS-1:0] araddr_q, araddr_d;
    logic [REQID-1:0] arid_q, arid_d;
    logic [7:0]       arlen_q, arlen_d;
    logic [1:0]       arburst_q, arburst_d;
    logic [8:0]       beat_q, beat_d;
    logic [ABITS:0]   count_q, count_d;
    logic [ABITS-1:0] wptr_q, wptr_d;
    logic [ABITS-1:0] rptr_q, rptr_d;
    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    mem_d [DEPTH];
    logic             err_q, err_d;

    logic [8:0]       free9;
    logic [8:0]       need9;
    logic [8:0]       len9;
    logic             in_idle;
    logic             len_ok;
    logic             fits;
    logic             ar_acc;
    logic             bad_req;
    logic             push;
    logic             push_ok;
    logic             full;
    logic             pop;
    logic             beat_bad;
    logic [EW-1:0]    wr_entry;
    logic [EW-1:0]    head;

    // Reservation check, channel handshakes and burst-length checking.
    always_comb begin
        in_idle   = (state_q == ST_IDLE);
        free9     = DEPTH9 - 9'(count_q);
        need9     = {1'b0, s_arlen} + 9'd1;
        len_ok    = ({1'b0, s_arlen} < DEPTH9);
        fits      = len_ok && (free9 >= need9);
        s_arready = reset_n && in_idle && fits;
        ar_acc    = s_arvalid && s_arready;
        bad_req   = in_idle && s_arvalid && !len_ok;
        m_arvalid = (state_q == ST_ISSUE);
        m_rready  = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
        push      = m_rvalid && m_rready;
        full      = (count_q == FULLC);
        push_ok   = push && !full;
        s_rvalid  = (count_q != '0);
        pop       = s_rvalid && s_rready;
        len9      = {1'b0, arlen_q};
        beat_bad  = 1'b0;
        if (push) begin
            if (m_rlast) begin
                beat_bad = (beat_q != len9);
            end else begin
                beat_bad = (beat_q > len9);
            end
        end
    end

    // Burst FSM: accept one request, issue it, then collect beats until RLAST.
    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        arid_d    = arid_q;
        arlen_d   = arlen_q;
        arburst_d = arburst_q;
        beat_d    = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (ar_acc) begin
                    araddr_d  = s_araddr;
                    arid_d    = s_arid;
                    arlen_d   = s_arlen;
                    arburst_d = s_arburst;
                    beat_d    = '0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (m_arready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (push && m_rlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (push && (beat_q != 9'h1ff)) begin
            beat_d = beat_q + 9'd1;
        end
    end

    // FWFT FIFO bookkeeping; beats carry the captured ID, not the returned one.
    always_comb begin
        mem_d    = mem_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        wr_entry = {m_rlast, m_rresp, arid_q, m_rdata};
        if (push_ok) begin
            mem_d[wptr_q] = wr_entry;
            wptr_d        = wptr_q + ABITS'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + ABITS'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + (ABITS + 1)'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - (ABITS + 1)'(1);
        end
    end

    // Sticky error: illegal length, RLAST misplacement or overflow.
    always_comb begin
        err_d = err_q | bad_req | beat_bad | (push && full);
    end

    // Control and captured AR fields.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            araddr_q  <= '0;
            arid_q    <= '0;
            arlen_q   <= '0;
            arburst_q <= '0;
            beat_q    <= '0;
            count_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            arid_q    <= arid_d;
            arlen_q   <= arlen_d;
            arburst_q <= arburst_d;
            beat_q    <= beat_d;
            count_q   <= count_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            err_q     <= err_d;
        end
    end

    // Beat storage; cleared on reset so the read side shows zeros.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign head      = mem_q[rptr_q];
    assign s_rlast   = head[EW-1];
    assign s_rresp   = head[EW-2 -: 2];
    assign s_rid     = head[WIDTH +: REQID];
    assign s_rdata   = head[WIDTH-1:0];
    assign m_araddr  = araddr_q;
    assign m_arid    = arid_q;
    assign m_arlen   = arlen_q;
    assign m_arburst = arburst_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_ddr3_fetch_rbuf.sv
// tb_ddr3_fetch_rbuf: bench for ddr3_fetch_rbuf with a bypass responder,
// a queue-based reference model, table vectors and hand-written corner sequences.
`timescale 1ns/1ps
module tb_ddr3_fetch_rbuf;

    localparam int WIDTH = 32;
    localparam int ADDRS = 23;
    localparam int REQID = 4;
    localparam int DEPTH = 16;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             s_arvalid = 1'b0;
    logic             s_arready;
    logic [ADDRS-1:0] s_araddr = '0;
    logic [REQID-1:0] s_arid = '0;
    logic [7:0]       s_arlen = '0;
    logic [1:0]       s_arburst = '0;
    logic             s_rvalid;
    logic             s_rready = 1'b0;
    logic             s_rlast;
    logic [1:0]       s_rresp;
    logic [REQID-1:0] s_rid;
    logic [WIDTH-1:0] s_rdata;
    logic             m_arvalid;
    logic             m_arready;
    logic [ADDRS-1:0] m_araddr;
    logic [REQID-1:0] m_arid;
    logic [7:0]       m_arlen;
    logic [1:0]       m_arburst;
    logic             m_rready;
    logic             m_rvalid;
    logic             m_rlast;
    logic [1:0]       m_rresp;
    logic [WIDTH-1:0] m_rdata;
    logic             err_o;

    always #5 clock = ~clock;

    ddr3_fetch_rbuf #(
        .WIDTH(WIDTH), .ADDRS(ADDRS), .REQID(REQID), .DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_arid(s_arid), .s_arlen(s_arlen), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rlast(s_rlast),
        .s_rresp(s_rresp), .s_rid(s_rid), .s_rdata(s_rdata),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arid(m_arid), .m_arlen(m_arlen), .m_arburst(m_arburst),
        .m_rready(m_rready), .m_rvalid(m_rvalid), .m_rlast(m_rlast),
        .m_rresp(m_rresp), .m_rdata(m_rdata), .err_o(err_o)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (updated once per cycle) ----------------
    typedef struct {
        logic             last;
        logic [1:0]       resp;
        logic [REQID-1:0] id;
        logic [WIDTH-1:0] data;
    } beat_t;

    beat_t            mq[$];
    bit               out_q = 0;
    bit               ar_done = 0;
    bit               exp_err = 0;
    logic [ADDRS-1:0] c_addr = '0;
    logic [REQID-1:0] c_id = '0;
    logic [7:0]       c_len = '0;
    logic [1:0]       c_burst = '0;
    int               c_beat = 0;
    int               popped = 0;

    always @(negedge clock) begin
        int    sz;
        bit    rdy, acc, hs_ar, push, pop;
        beat_t b;
        if (!reset_n) begin
            mq.delete();
            out_q   = 0;
            ar_done = 0;
            exp_err = 0;
        end else begin
            sz  = mq.size();
            rdy = !out_q && (int'(s_arlen) < DEPTH) &&
                  ((DEPTH - sz) >= int'(s_arlen) + 1);
            chk("s_rvalid", s_rvalid, sz != 0);
            if (sz != 0) begin
                chk("s_rdata", s_rdata, mq[0].data);
                chk("s_rid", s_rid, mq[0].id);
                chk("s_rlast", s_rlast, mq[0].last);
                chk("s_rresp", s_rresp, mq[0].resp);
            end
            chk("m_arvalid", m_arvalid, out_q && !ar_done);
            chk("m_rready", m_rready, out_q);
            chk("err_o", err_o, exp_err);
            if (out_q) begin
                chk("m_araddr", m_araddr, c_addr);
                chk("m_arid", m_arid, c_id);
                chk("m_arlen", m_arlen, c_len);
                chk("m_arburst", m_arburst, c_burst);
            end
            if (s_arvalid) chk("s_arready", s_arready, rdy);
            acc   = s_arvalid && rdy;
            hs_ar = out_q && !ar_done && m_arready;
            push  = out_q && m_rvalid;
            pop   = (sz != 0) && s_rready;
            if (!out_q && s_arvalid && int'(s_arlen) >= DEPTH) exp_err = 1;
            if (push) begin
                if (m_rlast ? (c_beat != int'(c_len)) : (c_beat > int'(c_len))) exp_err = 1;
                if (sz == DEPTH) begin
                    exp_err = 1;
                end else begin
                    b.last = m_rlast; b.resp = m_rresp; b.id = c_id; b.data = m_rdata;
                    mq.push_back(b);
                end
                c_beat++;
                if (m_rlast && ar_done) out_q = 0;
            end
            if (pop) begin
                void'(mq.pop_front());
                popped++;
            end
            if (hs_ar) ar_done = 1;
            if (acc) begin
                out_q = 1; ar_done = 0; c_beat = 0;
                c_addr = s_araddr; c_id = s_arid; c_len = s_arlen; c_burst = s_arburst;
            end
        end
    end

    // ---------------- bypass responder ----------------
    int bp_delay = 0;
    int bp_rate = 100;
    int bp_early = -1;

    initial begin
        bit bp_act;
        int bp_wait, bp_beat, bp_len;
        bp_act = 0; bp_wait = 0; bp_beat = 0; bp_len = 0;
        m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rresp = 0; m_rdata = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                bp_act = 0; bp_wait = 0;
            end else begin
                if (m_arvalid && m_arready) begin
                    bp_act = 1; bp_beat = 0; bp_len = int'(m_arlen); bp_wait = 0;
                end else if (m_arvalid) begin
                    bp_wait++;
                end
                if (m_rvalid && m_rready) begin
                    if (m_rlast) bp_act = 0;
                    else bp_beat++;
                end
            end
            @(posedge clock);
            #1;
            if (!reset_n) begin
                m_arready = 0; m_rvalid = 0; m_rlast = 0;
            end else begin
                m_arready = m_arvalid && (bp_wait >= bp_delay);
                if (bp_act && ($urandom_range(99) < 32'(bp_rate))) begin
                    m_rvalid = 1;
                    m_rdata  = $urandom;
                    m_rresp  = 2'($urandom_range(3));
                    m_rlast  = (bp_beat == bp_len) || (bp_beat == bp_early);
                end else begin
                    m_rvalid = 0; m_rlast = 0;
                end
            end
        end
    end

    // ---------------- requester helpers ----------------
    bit rr_rand = 0;

    task automatic tick();
        @(posedge clock);
        #2;
        if (rr_rand) s_rready = 1'($urandom_range(1));
    endtask

    task automatic send_ar(input logic [ADDRS-1:0] a, input logic [REQID-1:0] id,
                           input logic [7:0] len, input int limit);
        int n = 0;
        s_arvalid = 1; s_araddr = a; s_arid = id; s_arlen = len; s_arburst = 2'b01;
        #1;
        while (!s_arready && n < limit) begin
            tick(); #1; n++;
        end
        chk("ar_accept", s_arready, 1'b1);
        tick();
        s_arvalid = 0; s_araddr = ~a; s_arid = ~id; s_arlen = 8'($urandom); s_arburst = 2'b10;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while ((out_q || mq.size() != 0) && n < limit) begin
            tick(); n++;
        end
        chk("drain_done", out_q || mq.size() != 0, 1'b0);
    endtask

    task automatic wait_burst(input int limit);
        int n = 0;
        while (out_q && n < limit) begin
            tick(); n++;
        end
        chk("burst_done", out_q, 1'b0);
    endtask

    task automatic do_reset();
        s_arvalid = 0; s_rready = 0; rr_rand = 0;
        bp_delay = 0; bp_rate = 100; bp_early = -1;
        reset_n = 0;
        #1;
        chk("rst_s_arready", s_arready, 1'b0);
        chk("rst_s_rvalid", s_rvalid, 1'b0);
        chk("rst_m_arvalid", m_arvalid, 1'b0);
        chk("rst_m_rready", m_rready, 1'b0);
        chk("rst_err_o", err_o, 1'b0);
        chk("rst_m_araddr", m_araddr, '0);
        chk("rst_m_arid", m_arid, '0);
        chk("rst_m_arlen", m_arlen, '0);
        tick(); tick();
        reset_n = 1;
        tick();
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [ADDRS-1:0] addr;
        logic [REQID-1:0] id;
        logic [7:0]       len;
        int               ar_delay;
        int               rate;
        bit               rrand;
        int               early;
        int               exp_beats;
        bit               exp_err;
    } vec_t;

    vec_t vt[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, p0;
        vt[0] = '{23'h000100, 4'h5, 8'd3,  0, 100, 1'b0, -1, 4,  1'b0};
        vt[1] = '{23'h7ffff0, 4'hA, 8'd7,  5, 100, 1'b0, -1, 8,  1'b0};
        vt[2] = '{23'h012345, 4'h3, 8'd0,  1, 50,  1'b1, -1, 1,  1'b0};
        vt[3] = '{23'h2aaaa0, 4'hF, 8'd15, 2, 70,  1'b1, -1, 16, 1'b0};
        vt[4] = '{23'h000040, 4'h9, 8'd3,  0, 100, 1'b0, 2,  3,  1'b1};

        do_reset();
        for (int i = 0; i < 5; i++) begin
            do_reset();
            bp_delay = vt[i].ar_delay; bp_rate = vt[i].rate; bp_early = vt[i].early;
            rr_rand = vt[i].rrand;
            s_rready = !vt[i].rrand;
            p0 = popped;
            send_ar(vt[i].addr, vt[i].id, vt[i].len, 50);
            wait_drain(200);
            rr_rand = 0;
            chk("vec_err", err_o, vt[i].exp_err);
            chk("vec_beats", 32'(popped - p0), 32'(vt[i].exp_beats));
        end
        // after an early RLAST the FSM is back in IDLE and takes a new burst
        bp_early = -1;
        s_rready = 1;
        p0 = popped;
        send_ar(23'h000080, 4'h2, 8'd1, 5);
        wait_drain(50);
        chk("post_early_beats", 32'(popped - p0), 32'd2);

        // two len=7 bursts fill the FIFO; a third waits for 8 pops
        do_reset();
        send_ar(23'h001000, 4'h1, 8'd7, 50);
        send_ar(23'h001008, 4'h2, 8'd7, 50);
        wait_burst(50);
        chk("full_rvalid", s_rvalid, 1'b1);
        s_arvalid = 1; s_araddr = 23'h001010; s_arid = 4'h3; s_arlen = 8'd7; s_arburst = 2'b01;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("blocked_arready", s_arready, 1'b0);
            s_rready = 1;
            tick();
            s_rready = 0;
        end
        #1;
        chk("unblocked_arready", s_arready, 1'b1);
        tick();
        s_arvalid = 0;
        s_rready = 1;
        wait_drain(100);

        // push+pop together at count=DEPTH-1, then at count=1
        do_reset();
        send_ar(23'h002000, 4'h4, 8'd7, 50);
        send_ar(23'h002008, 4'h5, 8'd6, 50);
        wait_burst(50);
        send_ar(23'h002010, 4'h6, 8'd0, 50);
        n = 0;
        while (out_q && n < 20) begin
            tick(); s_rready = m_rvalid; n++;
        end
        s_rready = 0;
        chk("simul15_done", out_q, 1'b0);
        s_arvalid = 1; s_arlen = 8'd1; s_arid = 4'h7; s_araddr = 23'h002020;
        #1;
        chk("cnt15_arready", s_arready, 1'b0);
        s_arvalid = 0;
        n = 0;
        while (mq.size() > 1 && n < 40) begin
            s_rready = (mq.size() > 1);
            tick(); n++;
        end
        s_rready = 0;
        chk("cnt1_reached", s_rvalid, 1'b1);
        send_ar(23'h002030, 4'h8, 8'd3, 10);
        s_rready = 1;
        wait_drain(50);

        // illegal length: never accepted, error sticks
        do_reset();
        s_arvalid = 1; s_arlen = 8'd16; s_araddr = 23'h003000; s_arid = 4'hC;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("len16_arready", s_arready, 1'b0);
            tick();
        end
        s_arvalid = 0;
        chk("len16_err", err_o, 1'b1);

        // reset mid-burst with two beats buffered
        do_reset();
        send_ar(23'h004000, 4'hD, 8'd3, 50);
        n = 0;
        while (mq.size() < 2 && n < 20) begin
            tick(); n++;
        end
        #1;
        reset_n = 0;
        #1;
        chk("arst_s_rvalid", s_rvalid, 1'b0);
        chk("arst_m_rready", m_rready, 1'b0);
        chk("arst_m_arid", m_arid, '0);
        chk("arst_s_rdata", s_rdata, '0);
        chk("arst_s_arready", s_arready, 1'b0);
        tick(); tick();
        reset_n = 1;
        tick();
        p0 = popped;
        s_rready = 1;
        send_ar(23'h004010, 4'hE, 8'd3, 20);
        wait_drain(50);
        chk("post_rst_beats", 32'(popped - p0), 32'd4);
        chk("post_rst_err", err_o, 1'b0);

        // randomized bursts against the model
        do_reset();
        rr_rand = 1;
        for (int i = 0; i < 40; i++) begin
            bp_delay = $urandom_range(3);
            bp_rate = $urandom_range(100, 40);
            send_ar(ADDRS'($urandom), REQID'($urandom), 8'($urandom_range(15)), 300);
            repeat ($urandom_range(3)) tick();
        end
        rr_rand = 0;
        s_rready = 1;
        wait_drain(300);
        chk("rand_err", err_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
